// File: rtl/wb_arbiter.sv
// Write-back arbiter: per-FU 2-entry FIFOs with bypass and flush squash.
// Round-robin grant when WB_RR_ARB_EN is defined, else fixed FU0>FU1>FU2.
module wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  FU_valid,
  input  logic [95:0] FU_data,
  input  logic [8:0]  FU_rob_idx,
  output logic [2:0]  FU_ready,
  input  logic [7:0]  flush_mask,
  output logic        WB_valid,
  output logic [31:0] WB_data,
  output logic [2:0]  WB_rob_idx,
  output logic        busy
);

  logic [2:0][31:0] h_d, t_d, nh_d, nt_d;
  logic [2:0][2:0]  h_i, t_i, nh_i, nt_i;
  logic [2:0]       h_v, t_v, nh_v, nt_v;
  logic [2:0][31:0] in_d, c_d;
  logic [2:0][2:0]  in_i, c_i;
  logic [2:0]       acc, c_v, gnt;
  logic [31:0]      g_d;
  logic [2:0]       g_i;
  logic             out_v;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      in_d[i] = FU_data[32*i +: 32];
      in_i[i] = FU_rob_idx[3*i +: 3];
      acc[i]  = FU_valid[i] && !t_v[i];
      c_d[i]  = h_v[i] ? h_d[i] : in_d[i];
      c_i[i]  = h_v[i] ? h_i[i] : in_i[i];
      c_v[i]  = (h_v[i] || acc[i]) && !flush_mask[c_i[i]];
    end
  end

`ifdef WB_RR_ARB_EN
  logic [1:0] ptr;
  logic [2:0] j;

  always_comb begin
    gnt = '0;
    j   = '0;
    for (int k = 0; k < 3; k++) begin
      j = {1'b0, ptr} + 3'(k);
      if (j > 3'd2) j = j - 3'd3;
      if (gnt == '0 && c_v[j[1:0]]) gnt[j[1:0]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else begin
      unique case (1'b1)
        gnt[0]:  ptr <= 2'd1;
        gnt[1]:  ptr <= 2'd2;
        gnt[2]:  ptr <= 2'd0;
        default: ptr <= ptr;
      endcase
    end
  end
`else
  always_comb begin
    gnt = '0;
    priority case (1'b1)
      c_v[0]:  gnt = 3'b001;
      c_v[1]:  gnt = 3'b010;
      c_v[2]:  gnt = 3'b100;
      default: gnt = '0;
    endcase
  end
`endif

  always_comb begin
    g_d = '0;
    g_i = '0;
    for (int i = 0; i < 3; i++) begin
      if (gnt[i]) begin
        g_d = c_d[i];
        g_i = c_i[i];
      end
    end
  end

  // Survivors of pop/flush plus the new entry compact toward the head.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      logic k0, k1, kin;
      k0  = h_v[i] && !gnt[i] && !flush_mask[h_i[i]];
      k1  = t_v[i] && !flush_mask[t_i[i]];
      kin = acc[i] && !(gnt[i] && !h_v[i]) && !flush_mask[in_i[i]];
      nh_d[i] = h_d[i];
      nh_i[i] = h_i[i];
      nt_d[i] = t_d[i];
      nt_i[i] = t_i[i];
      nh_v[i] = 1'b0;
      nt_v[i] = 1'b0;
      if (k0) begin
        nh_v[i] = 1'b1;
        if (k1) begin
          nt_v[i] = 1'b1;
        end else if (kin) begin
          nt_d[i] = in_d[i];
          nt_i[i] = in_i[i];
          nt_v[i] = 1'b1;
        end
      end else if (k1) begin
        nh_d[i] = t_d[i];
        nh_i[i] = t_i[i];
        nh_v[i] = 1'b1;
        if (kin) begin
          nt_d[i] = in_d[i];
          nt_i[i] = in_i[i];
          nt_v[i] = 1'b1;
        end
      end else if (kin) begin
        nh_d[i] = in_d[i];
        nh_i[i] = in_i[i];
        nh_v[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_v        <= '0;
      t_v        <= '0;
      h_d        <= '0;
      t_d        <= '0;
      h_i        <= '0;
      t_i        <= '0;
      out_v      <= 1'b0;
      WB_data    <= '0;
      WB_rob_idx <= '0;
    end else begin
      h_v   <= nh_v;
      t_v   <= nt_v;
      h_d   <= nh_d;
      t_d   <= nt_d;
      h_i   <= nh_i;
      t_i   <= nt_i;
      out_v <= |gnt;
      if (|gnt) begin
        WB_data    <= g_d;
        WB_rob_idx <= g_i;
      end
    end
  end

  assign FU_ready = ~t_v;
  assign WB_valid = out_v && !flush_mask[WB_rob_idx];
  assign busy     = |h_v || |t_v || out_v;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter against a queue-based reference model.
// Follows the DUT build: define WB_RR_ARB_EN for both to test round-robin.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  FU_valid;
  logic [95:0] FU_data;
  logic [8:0]  FU_rob_idx;
  logic [2:0]  FU_ready;
  logic [7:0]  flush_mask;
  logic        WB_valid;
  logic [31:0] WB_data;
  logic [2:0]  WB_rob_idx;
  logic        busy;

  wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .FU_valid   (FU_valid),
    .FU_data    (FU_data),
    .FU_rob_idx (FU_rob_idx),
    .FU_ready   (FU_ready),
    .flush_mask (flush_mask),
    .WB_valid   (WB_valid),
    .WB_data    (WB_data),
    .WB_rob_idx (WB_rob_idx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  i;
  } ent_t;

  ent_t        q [3][$];
  logic        m_ov;
  logic [31:0] m_od;
  logic [2:0]  m_oi;
  int          ptr;
  bit          known = 0;
  int          nvec  = 0;
  int          nerr  = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h exp %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] v,
                      input logic [95:0] d, input logic [8:0] ix,
                      input logic [7:0] fl);
    logic [2:0] er;
    ent_t       inc [3];
    ent_t       c [3];
    bit         acc [3];
    bit         cv [3];
    bit         fq [3];
    int         g, st;
    @(negedge clk);
    rst = r; FU_valid = v; FU_data = d;
    FU_rob_idx = ix; flush_mask = fl;
    #1;
    if (known) begin
      for (int i = 0; i < 3; i++) er[i] = q[i].size() < 2;
      chk("ready", 64'(FU_ready), 64'(er));
      chk("wb_valid", 64'(WB_valid), 64'(m_ov && !fl[m_oi]));
      chk("wb_data", 64'(WB_data), 64'(m_od));
      chk("wb_idx", 64'(WB_rob_idx), 64'(m_oi));
      chk("busy", 64'(busy),
          64'(m_ov || q[0].size() + q[1].size() + q[2].size() > 0));
    end
    if (r) begin
      for (int i = 0; i < 3; i++) q[i].delete();
      m_ov = 0; m_od = 0; m_oi = 0; ptr = 0; known = 1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        inc[i].d = d[32*i +: 32];
        inc[i].i = ix[3*i +: 3];
        acc[i] = v[i] && q[i].size() < 2;
        fq[i] = q[i].size() > 0;
        c[i] = fq[i] ? q[i][0] : inc[i];
        cv[i] = (fq[i] || acc[i]) && !fl[c[i].i];
      end
`ifdef WB_RR_ARB_EN
      st = ptr;
`else
      st = 0;
`endif
      g = -1;
      for (int k = 0; k < 3; k++)
        if (g < 0 && cv[(st + k) % 3]) g = (st + k) % 3;
      m_ov = g >= 0;
      if (g >= 0) begin
        m_od = c[g].d; m_oi = c[g].i;
        if (fq[g]) void'(q[g].pop_front());
        ptr = (g + 1) % 3;
      end
      for (int i = 0; i < 3; i++) begin
        ent_t t[$];
        foreach (q[i][k]) if (!fl[q[i][k].i]) t.push_back(q[i][k]);
        q[i] = t;
        if (acc[i] && !(g == i && !fq[i]) && !fl[inc[i].i])
          q[i].push_back(inc[i]);
      end
    end
  endtask

  task automatic idle(input logic [7:0] fl);
    step(1'b0, 3'b000, 96'h0, 9'h0, fl);
  endtask

  task automatic do_rst();
    step(1'b1, 3'b000, 96'h0, 9'h0, 8'h0);
  endtask

  function automatic logic [95:0] dat(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input logic [31:0] c);
    return {c, b, a};
  endfunction

  function automatic logic [8:0] idx(input logic [2:0] a,
                                     input logic [2:0] b,
                                     input logic [2:0] c);
    return {c, b, a};
  endfunction

  initial begin
    rst = 1'b1; FU_valid = '0; FU_data = '0;
    FU_rob_idx = '0; flush_mask = '0;
    do_rst();
    idle(8'h0);
    chk("rst_ready", 64'(FU_ready), 64'h7);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_wbv", 64'(WB_valid), 64'h0);

    // single ALU result, one-cycle latency
    step(1'b0, 3'b001, dat(32'h11, 0, 0), idx(3, 0, 0), 8'h0);
    idle(8'h0);
    chk("alu_v", 64'(WB_valid), 64'h1);
    chk("alu_d", 64'(WB_data), 64'h11);
    chk("alu_i", 64'(WB_rob_idx), 64'h3);

    // all three FUs at once
    do_rst();
    step(1'b0, 3'b111, dat(32'hA, 32'hB, 32'hC), idx(1, 2, 3), 8'h0);
    for (int k = 1; k <= 3; k++) begin
      idle(8'h0);
      chk("all_i", 64'(WB_rob_idx), 64'(k));
      chk("all_rdy", 64'(FU_ready), 64'h7);
    end

    // ALU streaming while LSU results pile up
    do_rst();
    step(1'b0, 3'b101, dat(1, 0, 32'h20), idx(0, 0, 6), 8'h0);
    step(1'b0, 3'b101, dat(2, 0, 32'h21), idx(1, 0, 7), 8'h0);
    step(1'b0, 3'b001, dat(3, 0, 0), idx(2, 0, 0), 8'h0);
`ifndef WB_RR_ARB_EN
    chk("lsu_full", 64'(FU_ready[2]), 64'h0);
`endif
    step(1'b0, 3'b001, dat(4, 0, 0), idx(3, 0, 0), 8'h0);
    repeat (4) idle(8'h0);

    // flush one of two buffered MUL results
    do_rst();
    step(1'b0, 3'b011, dat(1, 32'h55, 0), idx(0, 5, 0), 8'h0);
    step(1'b0, 3'b011, dat(2, 32'h66, 0), idx(1, 6, 0), 8'h0);
    idle(8'h40);
`ifndef WB_RR_ARB_EN
    idle(8'h0);
    chk("fl_v", 64'(WB_valid), 64'h1);
    chk("fl_i", 64'(WB_rob_idx), 64'h5);
    idle(8'h0);
    chk("fl_gone", 64'(WB_valid), 64'h0);
`endif
    repeat (3) idle(8'h0);

    // output squashed in its own cycle
    do_rst();
    step(1'b0, 3'b001, dat(32'h44, 0, 0), idx(4, 0, 0), 8'h0);
    idle(8'h10);
    chk("sq_v", 64'(WB_valid), 64'h0);

    // reset with full FIFOs
    do_rst();
    repeat (3)
      step(1'b0, 3'b111, dat(7, 8, 9), idx(1, 2, 3), 8'h0);
    step(1'b1, 3'b111, dat(7, 8, 9), idx(1, 2, 3), 8'h0);
    idle(8'h0);
    chk("rf_rdy", 64'(FU_ready), 64'h7);
    chk("rf_busy", 64'(busy), 64'h0);
    chk("rf_wbv", 64'(WB_valid), 64'h0);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      logic [7:0] fl;
      fl = ($urandom % 5 == 0) ? 8'(1 << ($urandom % 8)) : 8'h0;
      step($urandom % 100 == 0, 3'($urandom),
           {$urandom, $urandom, $urandom}, 9'($urandom), fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
